// File: rtl/receiver_spi_mc.sv
// Multi-channel strobe receiver: per-channel sync, debounce and capture,
// with a round-robin arbiter forwarding one tagged word per cycle downstream.
module receiver_spi_mc #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEBOUNCE = 3,
    localparam int unsigned CH_W    = $clog2(CHANNELS)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [CHANNELS-1:0]        new_sig,
    input  logic [CHANNELS*WIDTH-1:0]  in_sig,
    input  logic                       q_full,
    input  logic                       clr_overrun,
    output logic [WIDTH-1:0]           processed_sig,
    output logic [CH_W-1:0]            src_chan,
    output logic                       sig_alert,
    output logic [CHANNELS-1:0]        overrun
);

    localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);
    localparam logic [CH_W-1:0]  PTR_RST = CH_W'(CHANNELS - 1);

    logic [CHANNELS-1:0]             s1_q, s2_q;
    logic [CHANNELS-1:0]             cond_q, cond_d;
    logic [CHANNELS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [CHANNELS-1:0]             pending_q, pending_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  hold_q, hold_d;
    logic [CHANNELS-1:0]             overrun_q, overrun_d;
    logic [CH_W-1:0]                 ptr_q, ptr_d;
    logic [WIDTH-1:0]                processed_q, processed_d;
    logic [CH_W-1:0]                 src_q, src_d;
    logic                            alert_q, alert_d;

    logic [CHANNELS-1:0]             rise_c;
    logic                            gnt_valid_c;
    logic [CH_W-1:0]                 gnt_idx_c;
    int unsigned                     idx_c;

    // Debounce: a change on s2 is accepted only after DEBOUNCE stable cycles.
    always_comb begin
        cond_d = cond_q;
        cnt_d  = cnt_q;
        rise_c = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (s2_q[k] == cond_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_MAX) begin
                cond_d[k] = s2_q[k];
                cnt_d[k]  = '0;
                rise_c[k] = s2_q[k];
            end else begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        gnt_valid_c = 1'b0;
        gnt_idx_c   = '0;
        idx_c       = 0;
        if (!q_full) begin
            for (int unsigned i = 1; i <= CHANNELS; i++) begin
                idx_c = (32'(ptr_q) + i) % CHANNELS;
                if (!gnt_valid_c && pending_q[CH_W'(idx_c)]) begin
                    gnt_valid_c = 1'b1;
                    gnt_idx_c   = CH_W'(idx_c);
                end
            end
        end
    end

    // Capture, pending/overrun bookkeeping and registered forward path.
    always_comb begin
        hold_d      = hold_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        ptr_d       = ptr_q;
        processed_d = processed_q;
        src_d       = src_q;
        alert_d     = gnt_valid_c;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            logic granted;
            granted = gnt_valid_c && (gnt_idx_c == CH_W'(k));
            if (rise_c[k]) begin
                hold_d[k] = in_sig[k*WIDTH +: WIDTH];
            end
            pending_d[k] = rise_c[k] | (pending_q[k] & ~granted);
            // A fresh capture over an unforwarded word is an overrun; set beats clear.
            overrun_d[k] = (rise_c[k] & pending_q[k] & ~granted)
                         | (overrun_q[k] & ~clr_overrun);
        end
        if (gnt_valid_c) begin
            processed_d = hold_q[gnt_idx_c];
            src_d       = gnt_idx_c;
            ptr_d       = gnt_idx_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q        <= '0;
            s2_q        <= '0;
            cond_q      <= '0;
            cnt_q       <= '0;
            pending_q   <= '0;
            hold_q      <= '0;
            overrun_q   <= '0;
            ptr_q       <= PTR_RST;
            processed_q <= '0;
            src_q       <= '0;
            alert_q     <= 1'b0;
        end else begin
            s1_q        <= new_sig;
            s2_q        <= s1_q;
            cond_q      <= cond_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            hold_q      <= hold_d;
            overrun_q   <= overrun_d;
            ptr_q       <= ptr_d;
            processed_q <= processed_d;
            src_q       <= src_d;
            alert_q     <= alert_d;
        end
    end

    assign processed_sig = processed_q;
    assign src_chan      = src_q;
    assign sig_alert     = alert_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_receiver_spi_mc.sv
// Directed bench for receiver_spi_mc: latency, debounce, round-robin order,
// overrun handling under q_full, async reset and same-cycle capture/grant.
module tb_receiver_spi_mc;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned CHANNELS = 4;

    logic                      clk;
    logic                      reset_n;
    logic [CHANNELS-1:0]       new_sig;
    logic [CHANNELS*WIDTH-1:0] in_sig;
    logic                      q_full;
    logic                      clr_overrun;
    logic [WIDTH-1:0]          processed_sig;
    logic [1:0]                src_chan;
    logic                      sig_alert;
    logic [CHANNELS-1:0]       overrun;

    int total = 0;
    int bad   = 0;
    int cnt;
    int acc;

    receiver_spi_mc #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEBOUNCE(3)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .new_sig       (new_sig),
        .in_sig        (in_sig),
        .q_full        (q_full),
        .clr_overrun   (clr_overrun),
        .processed_sig (processed_sig),
        .src_chan      (src_chan),
        .sig_alert     (sig_alert),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic count_alerts(input int n, output int c);
        c = 0;
        repeat (n) begin
            tick(1);
            if (sig_alert === 1'b1) c++;
        end
    endtask

    task automatic set_word(input int ch, input logic [31:0] w);
        in_sig[ch*WIDTH +: WIDTH] = w;
    endtask

    initial begin
        reset_n     = 1'b0;
        new_sig     = '0;
        in_sig      = '0;
        q_full      = 1'b0;
        clr_overrun = 1'b0;
        tick(2);
        chk("rst_alert", 32'(sig_alert), 32'h0);
        chk("rst_data", processed_sig, 32'h0);
        chk("rst_src", 32'(src_chan), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        reset_n = 1'b1;
        tick(2);

        // All four channels together: ch0..ch3 on consecutive cycles.
        for (int k = 0; k < 4; k++) set_word(k, 32'hA0 + 32'(k));
        new_sig = 4'hF;
        tick(5);
        chk("rr_pre", 32'(sig_alert), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("rr_alert", 32'(sig_alert), 32'h1);
            chk("rr_src", 32'(src_chan), 32'(k));
            chk("rr_data", processed_sig, 32'hA0 + 32'(k));
        end
        tick(1);
        chk("rr_end", 32'(sig_alert), 32'h0);
        new_sig = 4'h0;
        tick(8);

        // Single channel latency: six edges from drive to sig_alert.
        set_word(1, 32'hDEADBEEF);
        new_sig = 4'b0010;
        tick(5);
        chk("lat_pre", 32'(sig_alert), 32'h0);
        tick(1);
        chk("lat_alert", 32'(sig_alert), 32'h1);
        chk("lat_data", processed_sig, 32'hDEADBEEF);
        chk("lat_src", 32'(src_chan), 32'h1);
        tick(1);
        chk("lat_pulse", 32'(sig_alert), 32'h0);
        tick(3);
        new_sig = 4'b0000;
        count_alerts(10, cnt);
        chk("lat_single", 32'(cnt), 32'h0);

        // Two-cycle glitch is filtered, five-cycle strobe is forwarded once.
        set_word(0, 32'h55);
        new_sig = 4'b0001;
        tick(2);
        new_sig = 4'b0000;
        count_alerts(12, cnt);
        chk("glitch_cnt", 32'(cnt), 32'h0);
        chk("glitch_data", processed_sig, 32'hDEADBEEF);
        set_word(0, 32'h12345678);
        new_sig = 4'b0001;
        tick(5);
        new_sig = 4'b0000;
        count_alerts(12, cnt);
        chk("db_cnt", 32'(cnt), 32'h1);
        chk("db_data", processed_sig, 32'h12345678);
        chk("db_src", 32'(src_chan), 32'h0);

        // q_full blocks; second capture on ch2 overruns the first.
        q_full = 1'b1;
        acc = 0;
        set_word(2, 32'h11);
        new_sig = 4'b0100;
        count_alerts(8, cnt); acc += cnt;
        new_sig = 4'b0000;
        count_alerts(8, cnt); acc += cnt;
        set_word(2, 32'h22);
        new_sig = 4'b0100;
        count_alerts(8, cnt); acc += cnt;
        new_sig = 4'b0000;
        count_alerts(8, cnt); acc += cnt;
        chk("full_cnt", 32'(acc), 32'h0);
        chk("full_ovr", 32'(overrun), 32'h4);
        q_full = 1'b0;
        count_alerts(4, cnt);
        chk("drain_cnt", 32'(cnt), 32'h1);
        chk("drain_data", processed_sig, 32'h22);
        chk("drain_src", 32'(src_chan), 32'h2);
        chk("drain_ovr", 32'(overrun), 32'h4);
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        chk("clr_ovr", 32'(overrun), 32'h0);

        // ch0 re-captures on the same edge it is granted: no overrun.
        q_full = 1'b1;
        set_word(0, 32'h0A);
        new_sig = 4'b0001;
        tick(8);
        new_sig = 4'b0000;
        tick(8);
        set_word(0, 32'h0B);
        new_sig = 4'b0001;
        tick(4);
        q_full = 1'b0;
        tick(1);
        chk("same_alert0", 32'(sig_alert), 32'h1);
        chk("same_data0", processed_sig, 32'h0A);
        tick(1);
        chk("same_alert1", 32'(sig_alert), 32'h1);
        chk("same_data1", processed_sig, 32'h0B);
        chk("same_src1", 32'(src_chan), 32'h0);
        tick(1);
        chk("same_end", 32'(sig_alert), 32'h0);
        chk("same_ovr", 32'(overrun), 32'h0);
        tick(1);
        new_sig = 4'b0000;
        tick(8);

        // ch3 pending with overrun, then async reset discards everything.
        q_full = 1'b1;
        set_word(3, 32'h33);
        new_sig = 4'b1000;
        tick(8);
        new_sig = 4'b0000;
        tick(8);
        set_word(3, 32'h34);
        new_sig = 4'b1000;
        tick(8);
        new_sig = 4'b0000;
        tick(8);
        chk("pre_rst_ovr", 32'(overrun), 32'h8);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_data", processed_sig, 32'h0);
        chk("arst_alert", 32'(sig_alert), 32'h0);
        chk("arst_ovr", 32'(overrun), 32'h0);
        tick(1);
        reset_n = 1'b1;
        q_full  = 1'b0;
        count_alerts(6, cnt);
        chk("post_rst_cnt", 32'(cnt), 32'h0);
        set_word(0, 32'hC0);
        set_word(3, 32'hC3);
        new_sig = 4'b1001;
        tick(6);
        chk("ptr_alert0", 32'(sig_alert), 32'h1);
        chk("ptr_src0", 32'(src_chan), 32'h0);
        chk("ptr_data0", processed_sig, 32'hC0);
        tick(1);
        chk("ptr_src1", 32'(src_chan), 32'h3);
        chk("ptr_data1", processed_sig, 32'hC3);
        tick(1);
        chk("ptr_end", 32'(sig_alert), 32'h0);
        new_sig = 4'b0000;
        tick(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
